// File: rtl/inst_fetch_issue_if.sv
// rtl/inst_fetch_issue_if.sv - fetch/issue bus: instruction memory, redirect and decode handshake
interface inst_fetch_issue_if #(
  parameter int PC_W   = 16,
  parameter int INST_W = 32
);
  logic              imem_req;
  logic [PC_W-1:0]   imem_addr;
  logic [INST_W-1:0] imem_rdata;
  logic              flush;
  logic [PC_W-1:0]   flush_pc;
  logic              issue_valid;
  logic              issue_ready;
  logic [INST_W-1:0] issue_inst;
  logic [3:0]        issue_opcode;
  logic [PC_W-1:0]   issue_pc;
  logic              issue_illegal;

  modport master (
    output imem_req, imem_addr, issue_valid, issue_inst, issue_opcode, issue_pc, issue_illegal,
    input  imem_rdata, flush, flush_pc, issue_ready
  );

  modport slave (
    input  imem_req, imem_addr, issue_valid, issue_inst, issue_opcode, issue_pc, issue_illegal,
    output imem_rdata, flush, flush_pc, issue_ready
  );
endinterface

// File: rtl/inst_fetch_issue.sv
// rtl/inst_fetch_issue.sv - instruction fetch and prefetch queue feeding decode; optional ISSUE_OPCHECK_EN
module inst_fetch_issue #(
  parameter int PC_W   = 16,
  parameter int INST_W = 32,
  parameter int DEPTH  = 4
) (
  input  logic clk,
  input  logic rst,
  inst_fetch_issue_if.master bus
);
  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = PTR_W + 1;

  logic [INST_W-1:0] r_q_inst [DEPTH];
  logic [PC_W-1:0]   r_q_pc   [DEPTH];
  logic [PTR_W-1:0]  r_wr_ptr;
  logic [PTR_W-1:0]  r_rd_ptr;
  logic [CNT_W-1:0]  r_count;
  logic [PC_W-1:0]   r_pc;
  logic [PC_W-1:0]   r_ret_pc;
  logic              r_in_flight;

  logic              w_valid;
  logic              w_pop;
  logic              w_push;
  logic [CNT_W:0]    w_used;
  logic              w_req;
  logic [INST_W-1:0] w_head_inst;

  assign w_valid = (r_count != '0);
  assign w_pop   = w_valid & bus.issue_ready;
  // A word returning during a flush belongs to the old stream and is dropped.
  assign w_push  = r_in_flight & ~bus.flush;
  // Credit counts queued words plus the one in flight, less the word leaving this cycle.
  assign w_used  = {1'b0, r_count} + (CNT_W+1)'(r_in_flight) - (CNT_W+1)'(w_pop);
  assign w_req   = rst & ~bus.flush & (w_used < (CNT_W+1)'(DEPTH));

  // PC, pointers, occupancy and in-flight tracking; flush restarts everything at flush_pc.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_pc        <= '0;
      r_ret_pc    <= '0;
      r_in_flight <= 1'b0;
      r_wr_ptr    <= '0;
      r_rd_ptr    <= '0;
      r_count     <= '0;
    end else if (bus.flush) begin
      r_pc        <= bus.flush_pc;
      r_in_flight <= 1'b0;
      r_wr_ptr    <= '0;
      r_rd_ptr    <= '0;
      r_count     <= '0;
    end else begin
      r_in_flight <= w_req;
      if (w_req) begin
        r_pc     <= r_pc + PC_W'(1);
        r_ret_pc <= r_pc;
      end
      if (w_push) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + PTR_W'(1);
      r_count <= r_count + CNT_W'(w_push) - CNT_W'(w_pop);
    end
  end

  // Queue storage: returned word and its address written at the tail.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_q_inst[r_wr_ptr] <= bus.imem_rdata;
      r_q_pc[r_wr_ptr]   <= r_ret_pc;
    end
  end

  // Head outputs read straight from queue registers, zeroed while the queue is empty.
  assign w_head_inst      = w_valid ? r_q_inst[r_rd_ptr] : '0;
  assign bus.imem_req     = w_req;
  assign bus.imem_addr    = r_pc;
  assign bus.issue_valid  = w_valid;
  assign bus.issue_inst   = w_head_inst;
  assign bus.issue_opcode = w_head_inst[INST_W-1 -: 4];
  assign bus.issue_pc     = w_valid ? r_q_pc[r_rd_ptr] : '0;

`ifdef ISSUE_OPCHECK_EN
  // Opcodes with no decoder assignment are flagged but still issued.
  assign bus.issue_illegal = w_valid & ((w_head_inst[INST_W-1 -: 4] == 4'b0010) |
                                        (w_head_inst[INST_W-1 -: 4] == 4'b0011) |
                                        (w_head_inst[INST_W-1 -: 4] == 4'b0111));
`else
  assign bus.issue_illegal = 1'b0;
`endif
endmodule

// File: tb/tb_inst_fetch_issue.sv
// tb/tb_inst_fetch_issue.sv - directed self-checking bench for inst_fetch_issue
module tb_inst_fetch_issue;
  logic clk = 1'b0;
  logic rst = 1'b0;
  int   errors = 0;
  int   checks = 0;
  bit   use_table = 1'b0;

  always #5 clk = ~clk;

  inst_fetch_issue_if #(.PC_W(16), .INST_W(32)) bus ();

  inst_fetch_issue #(.PC_W(16), .INST_W(32), .DEPTH(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  function automatic logic [31:0] word_of(input logic [15:0] a);
    logic [3:0] op;
    op = 4'h8;
    if (use_table) begin
      case (a[1:0])
        2'd0:    op = 4'b0111;
        2'd1:    op = 4'b1101;
        2'd2:    op = 4'b0011;
        default: op = 4'h8;
      endcase
    end
    return {op, 12'h000, a};
  endfunction

  // Instruction memory: fixed one-cycle read latency.
  always @(posedge clk) bus.imem_rdata <= bus.imem_req ? word_of(bus.imem_addr) : 32'hDEAD_BEEF;

  // Holds reset for two cycles, releases it at a falling edge and leaves the bench in cycle 0.
  task automatic start(input bit rdy, input bit tbl);
    rst = 1'b0;
    bus.flush = 1'b0;
    bus.flush_pc = '0;
    bus.issue_ready = 1'b0;
    use_table = tbl;
    @(negedge clk);
    @(negedge clk);
    bus.issue_ready = rdy;
    rst = 1'b1;
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    bus.flush = 1'b0;
    bus.flush_pc = '0;
    bus.issue_ready = 1'b1;
    @(negedge clk);
    @(negedge clk);
    #1;
    checks++; if (bus.imem_req !== 1'b0) begin errors++; $display("FAIL reset_req got=%b exp=0", bus.imem_req); end
    checks++; if (bus.imem_addr !== 16'h0) begin errors++; $display("FAIL reset_addr got=%h exp=0", bus.imem_addr); end
    checks++; if (bus.issue_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got=%b exp=0", bus.issue_valid); end
    checks++; if (bus.issue_inst !== 32'h0) begin errors++; $display("FAIL reset_inst got=%h exp=0", bus.issue_inst); end
    checks++; if (bus.issue_opcode !== 4'h0) begin errors++; $display("FAIL reset_opcode got=%h exp=0", bus.issue_opcode); end
    checks++; if (bus.issue_pc !== 16'h0) begin errors++; $display("FAIL reset_pc got=%h exp=0", bus.issue_pc); end
    checks++; if (bus.issue_illegal !== 1'b0) begin errors++; $display("FAIL reset_illegal got=%b exp=0", bus.issue_illegal); end
  endtask

  task automatic test_stream();
    start(1'b1, 1'b0);
    for (int c = 0; c < 8; c++) begin
      if (c > 0) begin @(negedge clk); #1; end
      checks++; if (bus.imem_req !== 1'b1 || bus.imem_addr !== 16'(c)) begin
        errors++; $display("FAIL stream_req c=%0d got=%b/%h exp=1/%h", c, bus.imem_req, bus.imem_addr, 16'(c)); end
      checks++; if (bus.issue_valid !== (c >= 2)) begin
        errors++; $display("FAIL stream_valid c=%0d got=%b exp=%b", c, bus.issue_valid, (c >= 2)); end
      if (c >= 2) begin
        checks++; if (bus.issue_pc !== 16'(c-2) || bus.issue_opcode !== 4'b1000 || bus.issue_inst !== (32'h8000_0000 | 32'(c-2))) begin
          errors++; $display("FAIL stream_head c=%0d got=%h/%h/%h exp=%h/8/%h", c, bus.issue_pc, bus.issue_opcode,
                             bus.issue_inst, 16'(c-2), 32'h8000_0000 | 32'(c-2)); end
      end
    end
  endtask

  task automatic test_backpressure();
    start(1'b0, 1'b0);
    for (int c = 0; c < 10; c++) begin
      if (c > 0) begin @(negedge clk); #1; end
      checks++; if (bus.imem_req !== (c < 4) || (c < 4 && bus.imem_addr !== 16'(c))) begin
        errors++; $display("FAIL bp_fill c=%0d got=%b/%h exp=%b/%h", c, bus.imem_req, bus.imem_addr, (c < 4), 16'(c)); end
    end
    for (int r = 0; r < 6; r++) begin
      @(negedge clk);
      bus.issue_ready = 1'b1;
      #1;
      if (r == 0) begin
        checks++; if (bus.imem_req !== 1'b1 || bus.imem_addr !== 16'h4) begin
          errors++; $display("FAIL bp_resume got=%b/%h exp=1/0004", bus.imem_req, bus.imem_addr); end
      end
      checks++; if (bus.issue_valid !== 1'b1 || bus.issue_pc !== 16'(r)) begin
        errors++; $display("FAIL bp_drain r=%0d got=%b/%h exp=1/%h", r, bus.issue_valid, bus.issue_pc, 16'(r)); end
    end
  endtask

  task automatic test_flush();
    int got;
    start(1'b0, 1'b0);
    for (int c = 1; c < 4; c++) begin @(negedge clk); #1; end
    @(negedge clk);
    bus.flush = 1'b1;
    bus.flush_pc = 16'h0040;
    #1;
    checks++; if (bus.imem_req !== 1'b0) begin errors++; $display("FAIL flush_req got=%b exp=0", bus.imem_req); end
    @(negedge clk);
    bus.flush = 1'b0;
    bus.issue_ready = 1'b1;
    #1;
    checks++; if (bus.imem_req !== 1'b1 || bus.imem_addr !== 16'h0040 || bus.issue_valid !== 1'b0) begin
      errors++; $display("FAIL flush_restart got=%b/%h/%b exp=1/0040/0", bus.imem_req, bus.imem_addr, bus.issue_valid); end
    got = 0;
    for (int c = 0; c < 8 && got < 3; c++) begin
      @(negedge clk); #1;
      if (bus.issue_valid === 1'b1) begin
        checks++; if (bus.issue_pc !== 16'(16'h0040 + got)) begin
          errors++; $display("FAIL flush_issue n=%0d got=%h exp=%h", got, bus.issue_pc, 16'(16'h0040 + got)); end
        got++;
      end
    end
    checks++; if (got != 3) begin errors++; $display("FAIL flush_timeout got=%0d exp=3", got); end
  endtask

  task automatic test_wrap();
    int got;
    logic [15:0] exp_pc [4];
    exp_pc[0] = 16'hFFFE; exp_pc[1] = 16'hFFFF; exp_pc[2] = 16'h0000; exp_pc[3] = 16'h0001;
    start(1'b1, 1'b0);
    @(negedge clk);
    bus.flush = 1'b1;
    bus.flush_pc = 16'hFFFE;
    @(negedge clk);
    bus.flush = 1'b0;
    got = 0;
    for (int c = 0; c < 10 && got < 4; c++) begin
      if (c > 0) @(negedge clk);
      #1;
      if (bus.issue_valid === 1'b1) begin
        checks++; if (bus.issue_pc !== exp_pc[got]) begin
          errors++; $display("FAIL wrap_issue n=%0d got=%h exp=%h", got, bus.issue_pc, exp_pc[got]); end
        got++;
      end
    end
    checks++; if (got != 4) begin errors++; $display("FAIL wrap_timeout got=%0d exp=4", got); end
  endtask

  task automatic test_midreset();
    start(1'b0, 1'b0);
    for (int c = 1; c < 3; c++) begin @(negedge clk); #1; end
    @(negedge clk);
    rst = 1'b0;
    #1;
    checks++; if ({bus.imem_req, bus.imem_addr, bus.issue_valid, bus.issue_inst, bus.issue_opcode, bus.issue_pc, bus.issue_illegal} !== '0) begin
      errors++; $display("FAIL midreset_zero got=%b/%h/%b/%h/%h/%h/%b exp=all0", bus.imem_req, bus.imem_addr, bus.issue_valid,
                         bus.issue_inst, bus.issue_opcode, bus.issue_pc, bus.issue_illegal); end
    #1;
    rst = 1'b1;
    bus.issue_ready = 1'b1;
    #1;
    checks++; if (bus.imem_req !== 1'b1 || bus.imem_addr !== 16'h0 || bus.issue_valid !== 1'b0) begin
      errors++; $display("FAIL midreset_restart got=%b/%h/%b exp=1/0000/0", bus.imem_req, bus.imem_addr, bus.issue_valid); end
    @(negedge clk); #1;
    checks++; if (bus.issue_valid !== 1'b0 || bus.imem_addr !== 16'h1) begin
      errors++; $display("FAIL midreset_stale got=%b/%h exp=0/0001", bus.issue_valid, bus.imem_addr); end
    for (int k = 0; k < 2; k++) begin
      @(negedge clk); #1;
      checks++; if (bus.issue_valid !== 1'b1 || bus.issue_pc !== 16'(k)) begin
        errors++; $display("FAIL midreset_issue k=%0d got=%b/%h exp=1/%h", k, bus.issue_valid, bus.issue_pc, 16'(k)); end
    end
  endtask

  task automatic test_opcheck();
    logic [3:0] exp_op [3];
    logic       exp_ill [3];
    exp_op[0] = 4'b0111; exp_op[1] = 4'b1101; exp_op[2] = 4'b0011;
`ifdef ISSUE_OPCHECK_EN
    exp_ill[0] = 1'b1; exp_ill[1] = 1'b0; exp_ill[2] = 1'b1;
`else
    exp_ill[0] = 1'b0; exp_ill[1] = 1'b0; exp_ill[2] = 1'b0;
`endif
    start(1'b1, 1'b1);
    for (int c = 1; c < 5; c++) begin
      @(negedge clk); #1;
      if (c >= 2) begin
        checks++; if (bus.issue_valid !== 1'b1 || bus.issue_opcode !== exp_op[c-2] || bus.issue_illegal !== exp_ill[c-2]) begin
          errors++; $display("FAIL opcheck n=%0d got=%b/%b/%b exp=1/%b/%b", c-2, bus.issue_valid, bus.issue_opcode,
                             bus.issue_illegal, exp_op[c-2], exp_ill[c-2]); end
      end
    end
  endtask

  initial begin
    bus.flush = 1'b0;
    bus.flush_pc = '0;
    bus.issue_ready = 1'b0;
    test_reset();
    test_stream();
    test_backpressure();
    test_flush();
    test_wrap();
    test_midreset();
    test_opcheck();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
